// File: rtl/expr_result_unpacker_if.sv
// Result-bus bundle between the beat source, the unpacker and the regression checker.
// Ports: beat side in_data/in_valid/in_last/in_ready; frame side out_fields/out_parity/
//        out_valid/out_ready; status err_short/err_long/frame_cnt.
// master = source/checker side, slave = the unpacker itself.
interface expr_result_unpacker_if #(
  parameter int BEAT_W = 10,
  parameter int CNT_W  = 16
);
  logic [BEAT_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [143:0]      out_fields;
  logic              out_parity;
  logic              out_valid;
  logic              out_ready;
  logic              err_short;
  logic              err_long;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_fields, out_parity, out_valid, err_short, err_long, frame_cnt
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_fields, out_parity, out_valid, err_short, err_long, frame_cnt
  );
endinterface

// File: rtl/expr_result_unpacker.sv
// Reassembles the 90-bit {y0..y17} result word from MSB-first beats and splits it into
// 18 fields, each extended to 8 bits (signed when k mod 6 >= 3), plus a frame parity.
// Latency: out_valid 1 cycle after the last beat handshake. Backpressure: in_ready=0
// while a decoded frame waits for out_ready; frames of the wrong length raise
// err_short/err_long pulses and are dropped.
// Ports: clk, rst_n (async active-low), bus (slave modport of expr_result_unpacker_if).
module expr_result_unpacker #(
  parameter int BEAT_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  expr_result_unpacker_if.slave  bus
);

  localparam int NBEATS = 90 / BEAT_W;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  generate
    if (BEAT_W < 1 || BEAT_W > 90 || (90 % BEAT_W) != 0) begin : g_bad_beat_w
      $error("expr_result_unpacker: BEAT_W must divide 90");
    end
  endgenerate

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // Field k is 4+(k mod 3) bits wide; fields are packed MSB-first in groups of 15 bits.
  function automatic logic [143:0] decode(input logic [89:0] word);
    logic [143:0] res;
    logic [7:0]   mask;
    logic [7:0]   raw;
    int           wd;
    int           lsb;
    res = '0;
    for (int k = 0; k < 18; k++) begin
      wd   = 4 + (k % 3);
      lsb  = 90 - 15 * (k / 3) - ((k % 3 == 0) ? 0 : ((k % 3 == 1) ? 4 : 9)) - wd;
      mask = 8'((1 << wd) - 1);
      raw  = 8'(word >> lsb) & mask;
      if ((k % 6) >= 3 && raw[wd-1]) begin
        raw = raw | ~mask;
      end
      res[8*k +: 8] = raw;
    end
    return res;
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] beat_idx_q, beat_idx_d;
  logic [89:0]      shreg_q, shreg_d;
  logic [143:0]     out_fields_q, out_fields_d;
  logic             out_parity_q, out_parity_d;
  logic             out_valid_q, out_valid_d;
  logic             err_short_q, err_short_d;
  logic             err_long_q, err_long_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic             in_ready;
  logic             beat_acc;
  logic             is_final;
  logic [89:0]      word_next;

  assign in_ready  = (state_q != HOLD);
  assign beat_acc  = bus.in_valid && in_ready;
  assign is_final  = (beat_idx_q == LAST_IDX);
  // With BEAT_W=90 the shift empties the register, so the beat alone forms the word.
  assign word_next = (shreg_q << BEAT_W) | 90'(bus.in_data);

  always_comb begin
    state_d      = state_q;
    beat_idx_d   = beat_idx_q;
    shreg_d      = shreg_q;
    out_fields_d = out_fields_q;
    out_parity_d = out_parity_q;
    out_valid_d  = out_valid_q;
    err_short_d  = 1'b0;
    err_long_d   = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    case (state_q)
      COLLECT: begin
        if (beat_acc) begin
          if (is_final) begin
            beat_idx_d = '0;
            shreg_d    = '0;
            if (bus.in_last) begin
              out_fields_d = decode(word_next);
              out_parity_d = ^word_next;
              out_valid_d  = 1'b1;
              state_d      = HOLD;
            end else begin
              // Too many beats: drop this frame and skip ahead to the next in_last.
              err_long_d = 1'b1;
              state_d    = DRAIN;
            end
          end else if (bus.in_last) begin
            beat_idx_d  = '0;
            shreg_d     = '0;
            err_short_d = 1'b1;
          end else begin
            beat_idx_d = beat_idx_q + 1'b1;
            shreg_d    = word_next;
          end
        end
      end
      DRAIN: begin
        if (beat_acc && bus.in_last) begin
          state_d = COLLECT;
        end
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= COLLECT;
      beat_idx_q   <= '0;
      shreg_q      <= '0;
      out_fields_q <= '0;
      out_parity_q <= 1'b0;
      out_valid_q  <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_idx_q   <= beat_idx_d;
      shreg_q      <= shreg_d;
      out_fields_q <= out_fields_d;
      out_parity_q <= out_parity_d;
      out_valid_q  <= out_valid_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_fields = out_fields_q;
  assign bus.out_parity = out_parity_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.err_short  = err_short_q;
  assign bus.err_long   = err_long_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_expr_result_unpacker.sv
module tb_expr_result_unpacker;

  localparam int BEAT_W = 10;
  localparam int CNT_W  = 16;
  localparam int NBEATS = 90 / BEAT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  expr_result_unpacker_if #(.BEAT_W(BEAT_W), .CNT_W(CNT_W)) bus ();

  expr_result_unpacker #(.BEAT_W(BEAT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [143:0] f;
    logic         p;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_short = 0, exp_long = 0, seen_short = 0, seen_long = 0;
  int   mcnt = 0;
  int   rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
  bit   gaps = 0;
  int   yv[18];

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic int fw(input int k);
    return 4 + (k % 3);
  endfunction

  // Reference: concatenate the field values, then extend each one arithmetically.
  task automatic make_frame(output logic [89:0] word, output exp_t e);
    int v;
    word = '0;
    e.f  = '0;
    for (int k = 0; k < 18; k++) begin
      word = (word << fw(k)) | 90'(yv[k]);
      v = yv[k];
      if ((k % 6) >= 3 && v >= (1 << (fw(k) - 1))) v = v - (1 << fw(k)) + 256;
      e.f[8*k +: 8] = 8'(v);
    end
    e.p = (($countones(word) % 2) == 1);
  endtask

  task automatic rand_fields();
    for (int k = 0; k < 18; k++) yv[k] = $urandom_range(0, (1 << fw(k)) - 1);
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send_beat(input logic [BEAT_W-1:0] d, input logic last);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 2);
      if (n > 0) begin
        repeat (n) @(posedge clk);
        #1;
      end
    end
    n = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: in_ready got 0 required 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_word(input logic [89:0] word);
    for (int i = 0; i < NBEATS; i++)
      send_beat(BEAT_W'(word >> ((NBEATS - 1 - i) * BEAT_W)), (i == NBEATS - 1));
    check("out_valid_latency", bus.out_valid, 1'b1);
  endtask

  task automatic send_junk(input int len, input int err_at);
    for (int i = 0; i < len; i++) begin
      send_beat(BEAT_W'($urandom), (i == len - 1));
      if (i == err_at && err_at == NBEATS - 1) check("err_long_pulse", bus.err_long, 1'b1);
      if (i == err_at && err_at < NBEATS - 1) check("err_short_pulse", bus.err_short, 1'b1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending got %0d required 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // out_ready driver, 2 time units after the edge so mode changes at +1 apply this cycle.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.out_ready = 1'($urandom_range(0, 1));
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("in_ready_vs_hold", bus.in_ready, !bus.out_valid);
        if (bus.err_short) seen_short++;
        if (bus.err_long) seen_long++;
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: out_valid got 1 required 0");
          end else begin
            check("out_fields", bus.out_fields, q[0].f);
            check("out_parity", bus.out_parity, q[0].p);
            if (bus.out_ready) begin
              check("frame_cnt_at_xfer", bus.frame_cnt, 16'(mcnt));
              mcnt++;
              void'(q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    logic [89:0]  w;
    exp_t         e;
    logic [143:0] c;
    logic [15:0]  fc;
    int           kind;
    logic [7:0]   pat[6];

    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_fields", bus.out_fields, 144'h0);
    check("rst_frame_cnt", bus.frame_cnt, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_errs", {bus.err_short, bus.err_long, bus.out_parity}, 3'b000);
    @(posedge clk);
    #1;

    // All-ones frame: expectations written out directly.
    pat[0] = 8'h0F; pat[1] = 8'h1F; pat[2] = 8'h3F;
    pat[3] = 8'hFF; pat[4] = 8'hFF; pat[5] = 8'hFF;
    for (int k = 0; k < 18; k++) c[8*k +: 8] = pat[k % 6];
    e.f = c;
    e.p = 1'b0;
    q.push_back(e);
    w = '1;
    send_word(w);
    drain();
    check("frame_cnt_one", bus.frame_cnt, 16'd1);

    // Only y3=4'b1000 and y5=6'b011111.
    for (int k = 0; k < 18; k++) yv[k] = 0;
    yv[3] = 8;
    yv[5] = 31;
    make_frame(w, e);
    c = '0;
    c[31:24] = 8'hF8;
    c[47:40] = 8'h1F;
    e.f = c;
    e.p = 1'b0;
    q.push_back(e);
    send_word(w);
    drain();

    // Short frame: in_last on beat 4, then an immediate good frame.
    fc = bus.frame_cnt;
    exp_short++;
    send_junk(5, 4);
    @(posedge clk);
    #1;
    check("err_short_one_cycle", bus.err_short, 1'b0);
    check("frame_cnt_after_short", bus.frame_cnt, fc);
    rand_fields();
    make_frame(w, e);
    q.push_back(e);
    send_word(w);
    drain();

    // Long frame: 11 beats, in_last only on beat 10.
    exp_long++;
    send_junk(11, NBEATS - 1);
    rand_fields();
    make_frame(w, e);
    q.push_back(e);
    send_word(w);
    drain();

    // Consumer stalls for 5 cycles.
    rdy_mode = 2;
    rand_fields();
    make_frame(w, e);
    q.push_back(e);
    send_word(w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_in_ready", bus.in_ready, 1'b0);
      check("hold_out_valid", bus.out_valid, 1'b1);
    end
    rdy_mode = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("post_xfer_in_ready", bus.in_ready, 1'b1);
    check("post_xfer_out_valid", bus.out_valid, 1'b0);
    drain();

    // Reset mid-frame.
    for (int i = 0; i < 5; i++) send_beat(BEAT_W'($urandom), 1'b0);
    rst_n = 1'b0;
    #2;
    mcnt = 0;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_out_fields", bus.out_fields, 144'h0);
    check("midrst_misc", {bus.out_parity, bus.err_short, bus.err_long}, 3'b000);
    check("midrst_frame_cnt", bus.frame_cnt, 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    rand_fields();
    make_frame(w, e);
    q.push_back(e);
    send_word(w);
    drain();

    // Randomized traffic with gaps, backpressure and occasional bad frames.
    rdy_mode = 0;
    gaps = 1;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        exp_short++;
        send_junk($urandom_range(1, NBEATS - 1), -1);
      end else if (kind == 1) begin
        exp_long++;
        send_junk($urandom_range(NBEATS + 1, NBEATS + 3), -1);
      end else begin
        rand_fields();
        make_frame(w, e);
        q.push_back(e);
        send_word(w);
      end
    end
    rdy_mode = 1;
    drain();
    repeat (3) @(posedge clk);
    #1;

    check("end_queue_empty", 144'(q.size()), 144'h0);
    check("end_err_short_count", 144'(seen_short), 144'(exp_short));
    check("end_err_long_count", 144'(seen_long), 144'(exp_long));
    check("end_frame_cnt", bus.frame_cnt, 16'(mcnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
